// File: rtl/pc_fetch_stage_pkg.sv
// Shared types and defaults for the PC/fetch stage.
package pc_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_STOP  = 2'd2
  } fetch_state_e;

  localparam logic [3:0]  HLT_OPCODE_DEF = 4'hF;
  localparam logic [15:0] RESET_PC_DEF   = 16'h0000;

  function automatic logic is_hlt(input logic [3:0] opcode, input logic [3:0] hlt_op);
    return (opcode == hlt_op);
  endfunction

endpackage

// File: rtl/pc_fetch_stage_sat_counter.sv
// Saturating up-counter; cleared only by the asynchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Architectural PC holder and instruction fetch with req/ack memory handshake.
//
//  state | meaning
//  FETCH | request imem at pc_cur until ack, then capture instruction
//  HOLD  | instruction presented to decode; wait for retire (instr_ready)
//  STOP  | HLT retired or misaligned next PC; frozen until reset
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF[ADDR_W-1:0],
  parameter logic [3:0]        HLT_OPCODE = HLT_OPCODE_DEF,
  parameter int                STALL_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_next,
  input  logic               instr_ready,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [ADDR_W-1:0]  pc_cur,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               halted,
  output logic               align_err,
  output logic [STALL_W-1:0] stall_cnt
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic               align_q, align_d;
  logic               run_q;
  logic               req;
  logic               stall_inc;
  logic               hlt_hit;

  // run_q holds off the first request until the first edge after reset release.
  assign req       = run_q && (state_q == ST_FETCH);
  assign stall_inc = req && !imem_ack;
  assign hlt_hit   = is_hlt(instr_q[INSTR_W-1 -: 4], HLT_OPCODE);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    align_d  = align_q;
    case (state_q)
      ST_FETCH: begin
        if (req && imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          if (hlt_hit) begin
            halted_d = 1'b1;
            state_d  = ST_STOP;
          end else if (pc_next[0]) begin
            align_d = 1'b1;
            state_d = ST_STOP;
          end else begin
            pc_d    = pc_next;
            state_d = ST_FETCH;
          end
        end
      end
      ST_STOP: begin
        state_d = ST_STOP;
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      align_q  <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      align_q  <= align_d;
      run_q    <= 1'b1;
    end
  end

  sat_counter #(
    .W (STALL_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign pc_cur      = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign align_err   = align_q;

endmodule
